pe_mac_sat: RTL and testbench

- Next-generation systolic processing element for the MHA matrix engines: signed fixed-point multiply-accumulate with operand forwarding (X right, W down).
- Fully pipelined: accepts one operand pair every cycle with no issue gaps, instead of blocking while a multiply is in flight.
- Adds parametrised fraction width, round-to-nearest, a wide accumulator with guard bits, per-dot-product framing via I_LAST, and saturation with a sticky flag.
- Instantiated in 2-D arrays; each instance produces one output-stationary result per dot product.

---
 rtl/pe_mac_sat.sv | 169 ++++++++++++++++
 tb/tb_pe_mac_sat.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_sat.sv
// pe_mac_sat: systolic processing element. It computes a signed fixed-point
// multiply-accumulate and forwards its operands (X to the right, W downward).
//
// Pipeline: S1 multiplies. S2 rounds and rescales. S3 accumulates, and on the
// last term of a dot product it also produces the saturated result. The block
// accepts one term per cycle with no issue gaps.
//
// Ports:
//   I_CLK        clock, rising edge
//   I_ASYN_RSTN  asynchronous active-low reset
//   I_SYNC_RSTN  synchronous active-low clear (same effect as reset)
//   I_VLD        operand pair valid
//   I_LAST       final term of the current dot product (qualified by I_VLD)
//   I_X, I_W     activation / weight, two's complement QX.FRAC
//   O_VLD,O_LAST I_VLD / I_LAST delayed by one cycle
//   O_X, O_W     operands forwarded to the neighbours (load on I_VLD only)
//   O_D_VLD      one-cycle pulse: O_D / O_SAT hold a finished dot product
//   O_D          dot product, saturated to D_W bits
//   O_SAT        saturation occurred somewhere in the reported dot product
module pe_mac_sat #(
  parameter int D_W   = 16,
  parameter int FRAC  = 13,
  parameter int ACC_W = 24
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RSTN,
  input  logic           I_SYNC_RSTN,
  input  logic           I_VLD,
  input  logic           I_LAST,
  input  logic [D_W-1:0] I_X,
  input  logic [D_W-1:0] I_W,
  output logic           O_VLD,
  output logic           O_LAST,
  output logic [D_W-1:0] O_X,
  output logic [D_W-1:0] O_W,
  output logic           O_D_VLD,
  output logic [D_W-1:0] O_D,
  output logic           O_SAT
);

  localparam int P_W   = 2 * D_W;
  // The rounding add is done wide enough that p + half-LSB cannot wrap.
  // This also covers (-2^(D_W-1))^2.
  localparam int EXT_W = (ACC_W > P_W + 1) ? ACC_W : P_W + 1;

  localparam logic signed [EXT_W-1:0] RND     = {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] D_MAX   = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] D_MIN   = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

  // All state lives in one record, so both resets clear it with a single '0.
  typedef struct packed {
    logic             o_vld;
    logic             o_last;
    logic [D_W-1:0]   o_x;
    logic [D_W-1:0]   o_w;
    logic             s1_vld;
    logic             s1_last;
    logic [P_W-1:0]   s1_p;
    logic             s2_vld;
    logic             s2_last;
    logic [ACC_W-1:0] s2_r;
    logic             s2_rsat;   // the rescaled term itself had to be clamped
    logic [ACC_W-1:0] acc;
    logic             acc_open;  // 0 => the next valid term starts a new dot product
    logic             sticky;
    logic             o_d_vld;
    logic [D_W-1:0]   o_d;
    logic             o_sat;
  } state_t;

  state_t q, d;

  // S2 datapath: round half up, arithmetic shift, then narrow to ACC_W.
  // Narrowing saturates rather than wraps. When ACC_W >= 2*D_W-FRAC this is
  // identical to plain truncation. When ACC_W is smaller, a value that does
  // not fit is clamped and flagged instead of changing sign.
  logic signed [EXT_W-1:0]     p_ext;
  logic signed [EXT_W-1:0]     r_ext;
  logic [EXT_W-ACC_W:0]        r_hi;
  logic                        r_ovf;
  logic signed [ACC_W-1:0]     r_nar;

  // S3 datapath: accumulate at ACC_W+1 bits, clamp, then clamp to D_W.
  logic signed [ACC_W-1:0]     base;
  logic [ACC_W:0]              sum;
  logic                        acc_ovf;
  logic signed [ACC_W-1:0]     acc_nxt;
  logic                        sticky_nxt;
  logic                        d_hi;
  logic                        d_lo;
  logic [D_W-1:0]              d_nxt;

  always_comb begin
    p_ext   = EXT_W'($signed(q.s1_p));
    r_ext   = (p_ext + RND) >>> FRAC;
    r_hi    = r_ext[EXT_W-1:ACC_W-1];
    r_ovf   = !((&r_hi) || !(|r_hi));
    r_nar   = r_ovf ? (r_ext[EXT_W-1] ? ACC_MIN : ACC_MAX) : r_ext[ACC_W-1:0];

    base    = q.acc_open ? $signed(q.acc) : '0;
    sum     = {base[ACC_W-1], base} + {q.s2_r[ACC_W-1], q.s2_r};
    acc_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    acc_nxt = acc_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    // The previous dot product's sticky bit is dropped when a new one starts.
    sticky_nxt = (q.acc_open & q.sticky) | acc_ovf | q.s2_rsat;

    d_hi    = acc_nxt > D_MAX;
    d_lo    = acc_nxt < D_MIN;
    d_nxt   = d_hi ? D_MAX[D_W-1:0] : (d_lo ? D_MIN[D_W-1:0] : acc_nxt[D_W-1:0]);
  end

  always_comb begin
    // NOTE: start from the current state so every field has a value on every
    // path; anything not updated below holds, and no latch is inferred.
    d = q;

    // Forwarding
    d.o_vld  = I_VLD;
    d.o_last = I_LAST;
    if (I_VLD) begin
      d.o_x = I_X;
      d.o_w = I_W;
    end

    // S1: capture and multiply
    d.s1_vld  = I_VLD;
    d.s1_last = I_VLD & I_LAST;
    if (I_VLD) d.s1_p = $signed(I_X) * $signed(I_W);

    // S2: rescale
    d.s2_vld  = q.s1_vld;
    d.s2_last = q.s1_last;
    if (q.s1_vld) begin
      d.s2_r    = r_nar;
      d.s2_rsat = r_ovf;
    end

    // S3: accumulate. On a last term, also publish the result.
    d.o_d_vld = q.s2_vld & q.s2_last;
    if (q.s2_vld) begin
      d.acc      = acc_nxt;
      d.sticky   = sticky_nxt;
      d.acc_open = !q.s2_last;
      if (q.s2_last) begin
        d.o_d   = d_nxt;
        d.o_sat = sticky_nxt | d_hi | d_lo;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every stage
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN)      q <= '0;
    else if (!I_SYNC_RSTN) q <= '0;
    else                   q <= d;
  end

  assign O_VLD   = q.o_vld;
  assign O_LAST  = q.o_last;
  assign O_X     = q.o_x;
  assign O_W     = q.o_w;
  assign O_D_VLD = q.o_d_vld;
  assign O_D     = q.o_d;
  assign O_SAT   = q.o_sat;

endmodule

// File: tb/tb_pe_mac_sat.sv
// Self-checking bench for pe_mac_sat.
// Instance a uses the default parameters (ACC_W=24).
// Instance b uses ACC_W=18 so accumulator saturation can be reached.
// Both instances receive the same stimulus.
module tb_pe_mac_sat;

  logic        clk = 1'b0;
  logic        asyn_rstn, sync_rstn, vld, last;
  logic [15:0] x, w;

  logic        a_vld, a_last, a_d_vld, a_sat;
  logic [15:0] a_x, a_w, a_d;
  logic        b_vld, b_last, b_d_vld, b_sat;
  logic [15:0] b_x, b_w, b_d;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  pe_mac_sat dut_a (
    .I_CLK(clk), .I_ASYN_RSTN(asyn_rstn), .I_SYNC_RSTN(sync_rstn),
    .I_VLD(vld), .I_LAST(last), .I_X(x), .I_W(w),
    .O_VLD(a_vld), .O_LAST(a_last), .O_X(a_x), .O_W(a_w),
    .O_D_VLD(a_d_vld), .O_D(a_d), .O_SAT(a_sat)
  );

  pe_mac_sat #(.D_W(16), .FRAC(13), .ACC_W(18)) dut_b (
    .I_CLK(clk), .I_ASYN_RSTN(asyn_rstn), .I_SYNC_RSTN(sync_rstn),
    .I_VLD(vld), .I_LAST(last), .I_X(x), .I_W(w),
    .O_VLD(b_vld), .O_LAST(b_last), .O_X(b_x), .O_W(b_w),
    .O_D_VLD(b_d_vld), .O_D(b_d), .O_SAT(b_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (a_d_vld) pulses++;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] d;
    logic        sat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [15:0] xv, input logic [15:0] wv);
    vld = v; last = l; x = xv; w = wv;
  endtask

  task automatic term(input logic [15:0] xv, input logic [15:0] wv, input logic l);
    drive(1'b1, l, xv, wv);
    tick();
  endtask

  // Idle cycles carry junk operands so that the hold behaviour of O_X/O_W is exercised.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
      tick();
    end
  endtask

  task automatic wait_result(input string name);
    int k = 0;
    drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    while (!a_d_vld && k < 10) begin
      tick();
      k++;
    end
    check({name, "_pulse"}, a_d_vld, 1);
  endtask

  initial begin
    int p0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;

    vecs[0] = '{"one_x_half",   16'h2000, 16'h1000, 16'h1000, 1'b0};
    vecs[1] = '{"rnd_half_up",  16'h0001, 16'h1000, 16'h0001, 1'b0};
    vecs[2] = '{"rnd_neg_half", 16'hFFFF, 16'h1000, 16'h0000, 1'b0};
    vecs[3] = '{"rnd_3q",       16'h0003, 16'h0800, 16'h0001, 1'b0};
    vecs[4] = '{"rnd_neg_3q",   16'hFFFD, 16'h0800, 16'hFFFF, 1'b0};
    vecs[5] = '{"neg_one",      16'hE000, 16'h2000, 16'hE000, 1'b0};
    vecs[6] = '{"one_sq",       16'h2000, 16'h2000, 16'h2000, 1'b0};
    vecs[7] = '{"neg_one_max",  16'hE000, 16'h7FFF, 16'h8001, 1'b0};
    vecs[8] = '{"min_sq",       16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[9] = '{"min_max",      16'h8000, 16'h7FFF, 16'h8000, 1'b1};

    // Reset state
    asyn_rstn = 1'b0; sync_rstn = 1'b1;
    drive(1'b1, 1'b1, 16'h1234, 16'h5678);
    #2;
    check("rst_o_vld",   a_vld,   0);
    check("rst_o_x",     a_x,     0);
    check("rst_o_d_vld", a_d_vld, 0);
    check("rst_o_d",     a_d,     0);
    check("rst_o_sat",   a_sat,   0);
    tick();
    asyn_rstn = 1'b1;
    idle(2);

    // Basic latency: drive in cycle 0, O_X after edge 1, O_D_VLD after edge 3
    term(16'h2000, 16'h1000, 1'b1);
    check("lat_o_x",     a_x,     16'h2000);
    check("lat_o_w",     a_w,     16'h1000);
    check("lat_o_vld",   a_vld,   1);
    check("lat_o_last",  a_last,  1);
    check("lat_early",   a_d_vld, 0);
    idle(1);
    check("hold_o_x",    a_x,     16'h2000);
    check("hold_o_w",    a_w,     16'h1000);
    check("fwd_vld_low", a_vld,   0);
    idle(1);
    check("lat_d_vld",   a_d_vld, 1);
    check("lat_d",       a_d,     16'h1000);
    check("lat_sat",     a_sat,   0);
    idle(1);
    check("lat_pulse_end", a_d_vld, 0);
    check("lat_d_hold",    a_d,     16'h1000);

    // Single-term table
    for (int i = 0; i < 10; i++) begin
      term(vecs[i].x, vecs[i].w, 1'b1);
      wait_result(vecs[i].name);
      check({vecs[i].name, "_d"},   a_d,   vecs[i].d);
      check({vecs[i].name, "_sat"}, a_sat, vecs[i].sat);
      idle(1);
    end

    // Three terms with a 2-cycle bubble: 0.5 - 0.5 + 0.25
    idle(2);
    p0 = pulses;
    term(16'h2000, 16'h1000, 1'b0);
    term(16'hE000, 16'h1000, 1'b0);
    idle(2);
    term(16'h1000, 16'h1000, 1'b1);
    wait_result("three");
    check("three_d",   a_d,   16'h0800);
    check("three_sat", a_sat, 0);
    idle(4);
    check("three_one_pulse", pulses - p0, 1);

    // I_LAST without I_VLD is ignored
    p0 = pulses;
    drive(1'b0, 1'b1, 16'h0001, 16'h0001);
    tick();
    check("lastnv_o_last", a_last, 1);
    check("lastnv_o_vld",  a_vld,  0);
    idle(5);
    check("lastnv_no_pulse", pulses - p0, 0);

    // Output saturation followed immediately by a new dot product
    for (int i = 0; i < 4; i++) term(16'h3000, 16'h3000, i == 3);
    term(16'h2000, 16'h2000, 1'b1);
    wait_result("osat");
    check("osat_d",   a_d,   16'h7FFF);
    check("osat_sat", a_sat, 1);
    tick();
    check("b2b_pulse", a_d_vld, 1);
    check("b2b_d",     a_d,     16'h2000);
    check("b2b_sat",   a_sat,   0);
    idle(2);

    // Accumulator saturation on the ACC_W=18 instance
    for (int i = 0; i < 10; i++) term(16'h8000, 16'h8000, i == 9);
    wait_result("asat");
    check("asat_b_pulse", b_d_vld,     1);
    check("asat_b_acc",   dut_b.q.acc, 18'h1FFFF);
    check("asat_b_d",     b_d,         16'h7FFF);
    check("asat_b_sat",   b_sat,       1);
    check("asat_a_d",     a_d,         16'h7FFF);
    idle(2);

    // Asynchronous reset mid dot product
    p0 = pulses;
    term(16'h2000, 16'h2000, 1'b0);
    term(16'h2000, 16'h2000, 1'b0);
    drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    #1 asyn_rstn = 1'b0;
    #1;
    check("arst_o_x",     a_x,     0);
    check("arst_o_w",     a_w,     0);
    check("arst_o_d",     a_d,     0);
    check("arst_o_sat",   a_sat,   0);
    check("arst_o_d_vld", a_d_vld, 0);
    check("arst_b_d",     b_d,     0);
    tick();
    #2 asyn_rstn = 1'b1;
    idle(5);
    check("arst_no_pulse", pulses - p0, 0);
    term(16'h2000, 16'h2000, 1'b1);
    wait_result("arst_new");
    check("arst_new_d",   a_d,   16'h2000);
    check("arst_new_sat", a_sat, 0);
    idle(2);

    // Synchronous clear mid dot product
    p0 = pulses;
    term(16'h2000, 16'h2000, 1'b0);
    term(16'h2000, 16'h2000, 1'b0);
    drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    sync_rstn = 1'b0;
    tick();
    sync_rstn = 1'b1;
    check("srst_o_x",     a_x,     0);
    check("srst_o_d",     a_d,     0);
    check("srst_o_sat",   a_sat,   0);
    check("srst_o_d_vld", a_d_vld, 0);
    idle(5);
    check("srst_no_pulse", pulses - p0, 0);
    term(16'h2000, 16'h2000, 1'b1);
    wait_result("srst_new");
    check("srst_new_d",   a_d,   16'h2000);
    check("srst_new_sat", a_sat, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
